vram_writer: RTL and testbench

- Write-side engine for the display VRAM; the VGA path only reads, and this block supplies the VRAM write port.
- Accepts fill commands (start address, length, byte) from the CPU/bus side through a valid/ready handshake.
- Buffers commands in a small FIFO and drives vram_address, w_enable and w_data, one byte per cycle.
- A single-pixel write is a fill of length 1.

---
 rtl/vram_writer_if.sv | 13 +
 rtl/vram_writer.sv | 93 +++++++++
 tb/tb_vram_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_writer_if.sv
// vram_writer_if: fill-command valid/ready bus between the CPU side and the VRAM writer
interface vram_writer_if #(
  parameter int ADDR_W = 20,
  parameter int LEN_W = 20
);
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0] cmd_data;
  modport master(output cmd_valid, cmd_addr, cmd_len, cmd_data, input cmd_ready);
  modport slave(input cmd_valid, cmd_addr, cmd_len, cmd_data, output cmd_ready);
endinterface

// File: rtl/vram_writer.sv
// vram_writer: queued fill engine driving the VRAM write port; VRAM_WRITER_BLANK_GATE_EN gates writes to blanking
module vram_writer #(
  parameter int ADDR_W = 20,
  parameter int LEN_W = 20,
  parameter int VRAM_DEPTH = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef VRAM_WRITER_BLANK_GATE_EN
  input logic video_enable,
`endif
  vram_writer_if.slave cmd,
  output logic [ADDR_W-1:0] vram_address,
  output logic w_enable,
  output logic [7:0] w_data,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(VRAM_DEPTH - 1);
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [LEN_W-1:0] q_len [FIFO_DEPTH];
  logic [7:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0] remain;
  logic [7:0] data;
  logic push, pop, go;
  assign cmd.cmd_ready = fifo_count != FULL;
  assign push = cmd.cmd_valid && cmd.cmd_ready;
  assign pop = state == IDLE && fifo_count != '0;
`ifdef VRAM_WRITER_BLANK_GATE_EN
  assign go = state == RUN && !video_enable;
`else
  assign go = state == RUN;
`endif
  assign busy = state != IDLE || fifo_count != '0;
  // command storage, written on accept; contents never need a reset
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wp] <= cmd.cmd_addr;
      q_len[wp] <= cmd.cmd_len;
      q_data[wp] <= cmd.cmd_data;
    end
  // FIFO pointers and occupancy; a push and pop together leave the count alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      if (push != pop) fifo_count <= push ? fifo_count + (PW + 1)'(1) : fifo_count - (PW + 1)'(1);
    end
  // engine state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // zero-length commands are popped but never leave IDLE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((pop && q_len[rp] != '0) ? RUN : IDLE)
                             : ((go && remain == LEN_W'(1)) ? IDLE : RUN);
  end
  // fill datapath and registered write port; address wraps at the end of VRAM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_addr <= '0;
      remain <= '0;
      data <= '0;
      vram_address <= '0;
      w_data <= '0;
      w_enable <= 1'b0;
    end else begin
      w_enable <= go;
      if (pop) begin
        cur_addr <= q_addr[rp];
        remain <= q_len[rp];
        data <= q_data[rp];
      end
      if (go) begin
        vram_address <= cur_addr;
        w_data <= data;
        cur_addr <= cur_addr == LAST ? '0 : cur_addr + ADDR_W'(1);
        remain <= remain - LEN_W'(1);
      end
    end
endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: scoreboard bench for vram_writer against a timing-aware fill model
module tb_vram_writer;
  localparam int D = 307200;
  typedef struct {int a; int d; int t;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vram_writer_if #(.ADDR_W(20), .LEN_W(20)) cmd();
  logic [19:0] vram_address;
  logic w_enable;
  logic [7:0] w_data;
  logic busy;
  logic [2:0] fifo_count;
`ifdef VRAM_WRITER_BLANK_GATE_EN
  logic video_enable = 1'b0;
`endif
  vram_writer #(.ADDR_W(20), .LEN_W(20), .VRAM_DEPTH(D), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VRAM_WRITER_BLANK_GATE_EN
    .video_enable(video_enable),
`endif
    .cmd(cmd),
    .vram_address(vram_address),
    .w_enable(w_enable),
    .w_data(w_data),
    .busy(busy),
    .fifo_count(fifo_count)
  );
  wr_t expq[$];
  int pops[$];
  wr_t e;
  int cyc = 0, free_e = 0, vec = 0, bad = 0, nwr = 0;
  bit chk_t = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // model: a command accepted at edge N pops at max(N+1, engine free), writes on the L following edges
  task automatic model(input int a, input int l, input int d);
    int p;
    p = (cyc + 1 > free_e) ? cyc + 1 : free_e;
    pops.push_back(p);
    for (int i = 0; i < l; i++) expq.push_back('{(a + i) % D, d, p + 1 + i});
    free_e = p + l + 1;
  endtask
  task automatic chk_state();
    int n;
    if (!chk_t) return;
    while (pops.size() != 0 && pops[0] <= cyc) void'(pops.pop_front());
    n = pops.size();
    chk("fifo_count", int'(fifo_count), n);
    chk("cmd_ready", int'(cmd.cmd_ready), int'(n < 4));
    chk("busy", int'(busy), int'(n != 0 || cyc < free_e - 1));
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk_state();
    end
  endtask
  task automatic push(input int a, input int l, input int d);
    bit acc;
    int n = 0;
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_addr = 20'(a);
    cmd.cmd_len = 20'(l);
    cmd.cmd_data = 8'(d);
    do begin
      if (n != 0) @(negedge clk);
      chk_state();
      acc = cmd.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 3000);
    cmd.cmd_valid = 1'b0;
    if (!acc) begin
      vec++;
      bad++;
      $display("FAIL accept timeout: addr %0d not accepted in %0d cycles", a, n);
      return;
    end
    model(a, l, d);
  endtask
  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      chk_state();
      n++;
    end
    chk("drain pending", int'(expq.size() != 0 || busy), 0);
    idle(2);
  endtask
  // monitor: every observed write must match the head of the expected-write queue
  always @(negedge clk)
    if (rst_n && w_enable) begin
      if (expq.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL unexpected write: addr %0d data %0d (cycle %0d)", vram_address, w_data, cyc);
      end else begin
        e = expq.pop_front();
        chk("vram_address", int'(vram_address), e.a);
        chk("w_data", int'(w_data), e.d);
        if (chk_t) chk("write cycle", cyc, e.t);
      end
      nwr++;
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, n, a;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_addr = '0;
    cmd.cmd_len = '0;
    cmd.cmd_data = '0;
    #12;
    chk("reset w_enable", int'(w_enable), 0);
    chk("reset vram_address", int'(vram_address), 0);
    chk("reset w_data", int'(w_data), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset fifo_count", int'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    push(20'h00010, 1, 8'hE0);
    drain();
    push(100, 5, 8'h1C);
    drain();
    push(307198, 4, 8'h03);
    drain();
    push(0, 1000, 8'h55);
    for (int i = 0; i < 4; i++) push(5000 + i * 10, 2, 8'h60 + i);
    @(negedge clk);
    chk("full fifo_count", int'(fifo_count), 4);
    chk("full cmd_ready", int'(cmd.cmd_ready), 0);
    push(6000, 3, 8'h99);
    drain();
    push(5, 1, 8'h11);
    push(6, 0, 8'h22);
    push(7, 1, 8'h33);
    drain();
    push(1000, 50, 8'h77);
    push(2000, 3, 8'h01);
    push(3000, 3, 8'h02);
    k = nwr;
    n = 0;
    while (nwr < k + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async reset w_enable", int'(w_enable), 0);
    chk("async reset fifo_count", int'(fifo_count), 0);
    chk("async reset busy", int'(busy), 0);
    expq.delete();
    pops.delete();
    free_e = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? D - 1 - $urandom_range(0, 5) : $urandom_range(0, D - 1);
      push(a, $urandom_range(0, 8), $urandom_range(0, 255));
      idle($urandom_range(0, 3));
    end
    drain();
`ifdef VRAM_WRITER_BLANK_GATE_EN
    chk_t = 1'b0;
    push(D - 3, 12, 8'hAB);
    k = nwr;
    n = 0;
    while (nwr < k + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    video_enable = 1'b1;
    a = int'(vram_address);
    repeat (8) begin
      @(negedge clk);
      chk("stall w_enable", int'(w_enable), 0);
      chk("stall vram_address", int'(vram_address), a);
    end
    video_enable = 1'b0;
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
